// File: rtl/div_pkg.sv
// Shared types and defaults for the serial restoring divider.
package div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference when it does not go negative.
module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   part_rem,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] next_rem,
    output logic         q_bit
);

    logic [W:0] diff;

    // The running remainder is always below the divisor, so part_rem < 2*divisor
    // and the top difference bit alone tells whether the subtraction borrowed.
    always_comb begin
        diff     = part_rem - {1'b0, divisor};
        q_bit    = ~diff[W];
        next_rem = q_bit ? diff[W-1:0] : part_rem[W-1:0];
    end

endmodule

// File: rtl/div.sv
// Serial restoring radix-2 divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per cycle, with overflow and divide-by-zero detection.
module div
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [2*DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_q,
    output logic [DATA_WIDTH-1:0]   o_r,
    output logic                    o_err
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    state_t state, next_state;

    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  dvsr;
    logic [CW-1:0] count;

    logic [W-1:0]  q_res;
    logic [W-1:0]  r_res;
    logic          err_res;

    logic          accept;
    logic          op_err;
    logic          last_iter;
    logic [W-1:0]  step_rem;
    logic          step_bit;

    assign accept    = i_valid & i_ready;
    // A quotient fits in W bits only if the upper dividend half is below the divisor.
    assign op_err    = (i_a[2*W-1:W] >= i_b);
    assign last_iter = (count == CW'(W - 1));

    div_step #(
        .W(W)
    ) u_step (
        .part_rem({rem, quo[W-1]}),
        .divisor (dvsr),
        .next_rem(step_rem),
        .q_bit   (step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) next_state = op_err ? DONE : CALC;
            end
            CALC: begin
                if (last_iter) next_state = DONE;
            end
            DONE: begin
                if (accept) next_state = op_err ? DONE : CALC;
                else        next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        i_ready = (state != CALC);
        o_valid = (state == DONE);
    end

    // Result registers only change on the edge entering DONE, so the outputs
    // never show partial quotients.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            quo     <= '0;
            dvsr    <= '0;
            count   <= '0;
            q_res   <= '0;
            r_res   <= '0;
            err_res <= 1'b0;
        end else if (accept) begin
            rem   <= i_a[2*W-1:W];
            quo   <= i_a[W-1:0];
            dvsr  <= i_b;
            count <= '0;
            if (op_err) begin
                q_res   <= '1;
                r_res   <= '0;
                err_res <= 1'b1;
            end
        end else if (state == CALC) begin
            rem   <= step_rem;
            quo   <= {quo[W-2:0], step_bit};
            count <= count + CW'(1);
            if (last_iter) begin
                q_res   <= {quo[W-2:0], step_bit};
                r_res   <= step_rem;
                err_res <= 1'b0;
            end
        end
    end

    assign o_q   = q_res;
    assign o_r   = r_res;
    assign o_err = err_res;

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand width (W); even, >= 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_valid  input  1  request strobe; sampled on clk rising edge.
REQ-005 i_ready  output  1  block can accept a request this cycle.
REQ-006 i_a  input  2W  unsigned dividend.
REQ-007 i_b  input  W  unsigned divisor.
REQ-008 o_valid  output  1  one-cycle pulse: o_q/o_r/o_err valid.
REQ-009 o_q  output  W  unsigned quotient.
REQ-010 o_r  output  W  unsigned remainder.
REQ-011 o_err  output  1  divide-by-zero or quotient overflow.

Function
REQ-012 Serial restoring radix-2 divider, 2W/W -> W quotient and W remainder, one quotient bit per cycle; inverse operation of the serial Booth multiplier.
REQ-013 FSM states IDLE, CALC, DONE; i_ready = 1 in IDLE and DONE, 0 in CALC.
REQ-014 Accept = i_valid & i_ready at a rising edge; i_a and i_b captured into internal registers; later input changes have no effect.
REQ-015 i_valid while i_ready = 0 is ignored; no queuing.
REQ-016 On accept, error check: i_b >= 0 is not enough -- error when i_a[2W-1:W] >= i_b (this includes i_b == 0).
REQ-017 Error accept: next state DONE; o_q = all ones, o_r = 0, o_err = 1; o_valid high 1 cycle after accept edge.
REQ-018 Normal accept: remainder reg = i_a[2W-1:W], quotient reg = i_a[W-1:0], iteration count = 0, next state CALC.
REQ-019 Each CALC cycle: shift {rem,q} left 1 with (W+1)-bit partial remainder {carry,rem}; if >= divisor, subtract divisor and set q[0] = 1, else q[0] = 0.
REQ-020 CALC performs exactly W iterations, then DONE; o_valid high during DONE, exactly W cycles after accept edge.
REQ-021 DONE lasts one cycle; o_valid = 1 only in DONE; next state IDLE, or CALC/DONE if a new request is accepted in DONE (back-to-back, no bubble).
REQ-022 o_q, o_r, o_err hold last result from DONE until the next result's DONE cycle; undefined-looking intermediate values never appear on them.
REQ-023 Result invariant when o_err = 0: i_a == o_q * i_b + o_r and o_r < i_b.
REQ-024 Counter width $clog2(W+1); no wrap within an operation.

Reset
REQ-025 rst_n low forces immediately: state IDLE, o_valid 0, o_q 0, o_r 0, o_err 0, counter 0, internal operand regs 0.
REQ-026 Reset during CALC abandons the operation; no o_valid for it after release.
REQ-027 First accept possible on the first rising edge with rst_n high.

Structure
REQ-028 State enum type and default width constant live in shared package div_pkg.
REQ-029 One combinational sub-module div_step (W parameter): inputs partial remainder (W+1 bits), divisor; outputs next remainder and quotient bit.
REQ-030 Datapath: one W+1-bit subtractor; no multiplier or divider operators.

Verification (DATA_WIDTH = 8)
REQ-031 i_a = 16'd100, i_b = 8'd7 -> o_q = 14, o_r = 2, o_err = 0, o_valid 8 cycles after accept, i_ready low for 8 cycles.
REQ-032 i_a = 16'hFEFF, i_b = 8'hFF -> o_q = 8'hFF, o_r = 8'hFE, o_err = 0.
REQ-033 i_a = 16'h0700, i_b = 8'd7 (overflow) and i_a = 16'd5, i_b = 0 (div-zero) -> o_q = 8'hFF, o_r = 0, o_err = 1, o_valid 1 cycle after accept.
REQ-034 New request held on i_valid during DONE of 100/7 -> accepted that edge; second result 8 cycles later; i_valid pulses during CALC produce no extra results.
REQ-035 rst_n low 4 cycles into CALC -> all outputs 0 immediately, no o_valid after release, i_ready high; next 200/9 -> o_q = 22, o_r = 2.
REQ-036 10k random operands -> REQ-023 invariant checked against reference model, including o_err cases.
